// File: rtl/score_pkg.sv
// Shared types and default sizing for the score event scheduler.
//   sched_state_t : scheduler FSM state encoding
//   *_DEF         : default parameter values used by the top and its interface
package score_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } sched_state_t;

    localparam int N_SRC_DEF       = 4;
    localparam int PEND_W_DEF      = 6;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/score_event_sched_if.sv
// Gameplay-side bundle for the score event scheduler.
//   game_active, clear, hit : driven by gameplay/collision logic (master)
//   inc_req, pending,
//   overflow, busy          : driven by the scheduler (slave)
interface score_event_sched_if
    import score_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int PEND_W = PEND_W_DEF
) ();

    logic              game_active;
    logic              clear;
    logic [N_SRC-1:0]  hit;
    logic              inc_req;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic              busy;

    modport master (
        output game_active, clear, hit,
        input  inc_req, pending, overflow, busy
    );

    modport slave (
        input  game_active, clear, hit,
        output inc_req, pending, overflow, busy
    );

endinterface

// File: rtl/vsync_edge_sync.sv
// Brings an asynchronous vsync into the clk domain and flags its rising edge.
//   clk      : system clock
//   reset    : asynchronous, active-high
//   async_in : raw vsync
//   rise     : one-cycle pulse, SYNC_STAGES+1 cycles after the raw edge (+/-1)
// Every flop resets to 1 so a vsync that is already high when reset
// releases is not mistaken for a fresh frame boundary.
module vsync_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/score_event_sched.sv
// Score event scheduler: accumulates collision hits into a saturating
// backlog and releases one point per frame to the vsync-domain score counter.
//   clk   : system clock
//   reset : asynchronous, active-high
//   vsync : raw vertical sync (asynchronous)
//   bus   : gameplay inputs (game_active, clear, hit) and scheduler
//           outputs (inc_req, pending, overflow, busy)
//
// state   | meaning
// --------+--------------------------------------------------
// STOPPED | no game; hits ignored, inc_req held at 0
// RUN     | hits accumulate, one point issued per frame
// DRAIN   | game over; hits ignored, backlog still issued
module score_event_sched
    import score_pkg::*;
#(
    parameter int N_SRC       = N_SRC_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    score_event_sched_if.slave bus
);

    localparam int CNT_W = $clog2(N_SRC + 1);
    // One spare bit above pending+add so the saturation compare never wraps.
    localparam int SUM_W = PEND_W + CNT_W + 1;
    localparam logic [SUM_W-1:0] PEND_MAX = {{(SUM_W-PEND_W){1'b0}}, {PEND_W{1'b1}}};

    sched_state_t      state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              inc_req_q, inc_req_d;
    logic              busy_q;

    logic              vs_rise;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  add;
    logic              issue;
    logic [SUM_W-1:0]  sum;

    vsync_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vsync),
        .rise     (vs_rise)
    );

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            hit_cnt = hit_cnt + CNT_W'(bus.hit[i]);
        end
    end

    assign add   = (state_q == RUN) ? hit_cnt : '0;
    assign issue = vs_rise && (state_q != STOPPED) && (pending_q != '0);
    // issue only fires with pending_q != 0, so the subtraction cannot underflow.
    assign sum   = SUM_W'(pending_q) + SUM_W'(add) - SUM_W'(issue);

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (bus.game_active)                  state_d = RUN;
            RUN:     if (!bus.game_active)                 state_d = DRAIN;
            DRAIN: begin
                if (bus.game_active)                       state_d = RUN;
                else if (vs_rise && (pending_q == '0))     state_d = STOPPED;
            end
            default:                                       state_d = STOPPED;
        endcase
    end

    always_comb begin
        inc_req_d  = inc_req_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        if (state_q == STOPPED) begin
            inc_req_d = 1'b0;
        end else if (vs_rise) begin
            inc_req_d = issue;
        end

        if (bus.clear) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end else if (sum > PEND_MAX) begin
            pending_d  = '1;
            overflow_d = 1'b1;
        end else begin
            pending_d  = sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STOPPED;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            inc_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            inc_req_q  <= inc_req_d;
            busy_q     <= (state_d != STOPPED);
        end
    end

    assign bus.inc_req  = inc_req_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/score_event_sched.md
# score_event_sched

Sequences score increments from gameplay into the frame-rate BCD score counter. Multiple collision sources can fire hits on the same clock, and several hits can arrive within one frame. The score counter accepts at most one increment per vertical sync edge. This block sits between the enemy/projectile collision logic (clk domain) and the score counter/display path (vsync domain). It accumulates hits in a saturating pending counter and presents a frame-stable increment request, one point per frame, until the backlog is drained.

## Interface
Parameters:
- N_SRC, 4: number of collision sources
- PEND_W, 6: pending-hit counter width; saturates at 2^PEND_W-1
- SYNC_STAGES, 2: vsync synchronizer depth, minimum 2

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  reset, asynchronous, active-high
- vsync  in  1  raw vertical sync, asynchronous to clk; rising edge = frame boundary
- game_active  in  1  level; high while a game is in progress
- clear  in  1  synchronous single-cycle flush of backlog
- hit  in  N_SRC  single-cycle hit pulses, one bit per source, any combination per cycle
- inc_req  out  1  registered level; sampled by the score counter on vsync rising edge; 1 = add one point this frame
- pending  out  PEND_W  current backlog count
- overflow  out  1  sticky; set when hits were lost to saturation
- busy  out  1  high in RUN or DRAIN

## Operation
- vsync path:
  - SYNC_STAGES flops, then an edge register.
  - vs_rise = sync_out & ~prev.
  - All of these flops reset to 1, so vsync already high at reset release produces no spurious edge.
- States (in score_pkg):
  - STOPPED, reset state: hits ignored; inc_req forced 0.
  - RUN: hits accumulate; one point issued per vs_rise.
  - DRAIN: new hits ignored; issuing continues.
- Transitions:
  - STOPPED -> RUN when game_active=1.
  - RUN -> DRAIN when game_active=0.
  - DRAIN -> RUN when game_active=1.
  - DRAIN -> STOPPED on the vs_rise cycle where pending=0. inc_req is loaded 0 on that edge.
- Accepted hits per cycle: add = popcount(hit) in RUN, 0 otherwise.
- On a vs_rise cycle, outside STOPPED:
  - issue = (pending != 0).
  - inc_req <= issue.
  - dec = issue.
- On a cycle without vs_rise: inc_req holds; dec = 0.
- Pending update:
  - next = pending + add - dec, computed at PEND_W+$clog2(N_SRC+1)+1 bits, unsigned.
  - If next > 2^PEND_W-1: pending <= max and overflow <= 1.
  - A hit arriving in the same cycle as a decrement is never lost. Example: pending=1 with add=1 and dec=1 gives pending=1.
- clear:
  - Sets pending <= 0 and overflow <= 0 in the same cycle.
  - inc_req is unaffected until the next vs_rise.
  - clear takes priority over add/dec.
- reset:
  - Mid-frame reset drops inc_req to 0 immediately.
  - The score counter therefore sees no increment at the next vsync edge.
- Reset values: inc_req=0, pending=0, overflow=0, busy=0, state=STOPPED.

## Timing
- vs_rise asserts SYNC_STAGES+1 clk cycles after the vsync edge, with a 1-cycle uncertainty.
- inc_req and pending update on the clock edge ending the vs_rise cycle. Worst case this is about 4 clk (80 ns) after the raw vsync edge.
- inc_req then stays stable for the rest of the frame, so it is settled long before the next vsync edge. The consumer's setup/hold on vsync is met by construction.
- Each point is counted by the consumer exactly one frame after being issued.
- Hit-to-pending latency is 1 clk. pending and busy are registered.
- Throughput is 1 point per frame. A backlog of P points drains in P frames.

## Structure
- score_pkg:
  - sched_state_t enum {STOPPED, RUN, DRAIN}.
  - Default constants N_SRC_DEF=4, PEND_W_DEF=6.
- Sub-module vsync_edge_sync(SYNC_STAGES):
  - Ports: clk, reset, async_in, rise.
  - Handles synchronizer, edge register, and reset-to-1 behaviour.
  - Shared with any other block consuming vsync in the clk domain.
- Top holds the FSM, popcount, saturating pending arithmetic, and the inc_req register.

## Test plan
- Reset with vsync held high, release, no hits -> no vs_rise; inc_req=0 and pending=0 for 3 frames.
- game_active=1, hit=4'b1011 for one cycle -> pending=3 next cycle. Next 3 vsync edges each load inc_req=1; the 4th edge loads inc_req=0; pending reads 2,1,0.
- pending=1, hit=4'b0001 in the exact vs_rise cycle -> inc_req=1, pending stays 1.
- PEND_W=6, pending=62, hit=4'b1111 -> pending=63, overflow=1. clear then gives pending=0, overflow=0.
- pending=5, drop game_active, keep hitting -> state DRAIN; hits ignored; 5 frames of inc_req=1. On the next edge inc_req=0, state STOPPED, busy=0.
- inc_req=1 mid-frame, assert reset for 2 clk -> inc_req=0 immediately; all outputs at reset values; no inc at the next vsync edge.
